// File: rtl/argmax_collector_pkg.sv
// Shared defaults and FSM encoding for the argmax collector.
package argmax_collector_pkg;

    localparam int N_NEURONS_DEF = 10;
    localparam int DW_DEF        = 8;
    localparam int IDX_W_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/argmax_collector_cmp.sv
// Signed strict-greater compare; an equal candidate loses so ties keep the earlier index.
module argmax_collector_cmp #(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0] cand,
    input  logic signed [DW-1:0] best,
    output logic                 cand_wins
);

    assign cand_wins = (cand > best);

endmodule

// File: rtl/argmax_collector.sv
// Captures a layer's packed results over ready/received, scans them one per cycle and
// reports the argmax over done/ack. Define ARGMAX_TOP2_EN to also track the runner-up.
module argmax_collector
    import argmax_collector_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int DW        = DW_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ready,
    input  logic [N_NEURONS*DW-1:0]   layer_data,
    output logic                      received,
    output logic                      done,
    input  logic                      ack,
    output logic [IDX_W-1:0]          class_idx,
    output logic signed [DW-1:0]      max_value
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDX_W-1:0]          second_idx,
    output logic signed [DW-1:0]      second_val
`endif
);

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic signed [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};

    state_e                    state_q, state_d;
    logic [N_NEURONS*DW-1:0]   cap_q, cap_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic                      received_q, received_d;
    logic                      done_q, done_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [DW-1:0]      max_q, max_d;
    logic signed [DW-1:0]      elem;
    logic                      elem_gt_max;

    always_comb begin
        elem = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (cnt_q == IDX_W'(i)) elem = cap_q[DW*i +: DW];
        end
    end

    argmax_collector_cmp #(.DW(DW)) u_cmp_max (
        .cand      (elem),
        .best      (max_q),
        .cand_wins (elem_gt_max)
    );

`ifdef ARGMAX_TOP2_EN
    logic [IDX_W-1:0]     sec_idx_q, sec_idx_d;
    logic signed [DW-1:0] sec_val_q, sec_val_d;
    logic                 elem_gt_sec;

    argmax_collector_cmp #(.DW(DW)) u_cmp_sec (
        .cand      (elem),
        .best      (sec_val_q),
        .cand_wins (elem_gt_sec)
    );
`endif

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        received_d = received_q;
        done_d     = done_q;
        idx_d      = idx_q;
        max_d      = max_q;
`ifdef ARGMAX_TOP2_EN
        sec_idx_d  = sec_idx_q;
        sec_val_d  = sec_val_q;
`endif
        case (state_q)
            IDLE: begin
                if (ready) begin
                    cap_d      = layer_data;
                    received_d = 1'b1;
                    state_d    = ACK;
                end
            end
            ACK: begin
                // Four-phase: wait for the layer to drop ready before scanning.
                if (!ready) begin
                    received_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q == '0) begin
                    max_d = elem;
                    idx_d = '0;
`ifdef ARGMAX_TOP2_EN
                    sec_idx_d = '0;
                    sec_val_d = MIN_VAL;
`endif
                end else if (elem_gt_max) begin
                    max_d = elem;
                    idx_d = cnt_q;
`ifdef ARGMAX_TOP2_EN
                    sec_idx_d = idx_q;
                    sec_val_d = max_q;
                end else if (elem_gt_sec) begin
                    sec_idx_d = cnt_q;
                    sec_val_d = elem;
`endif
                end
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // done rises on the first DONE edge; ack only counts once it is visible.
                if (done_q && ack) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            cnt_q      <= '0;
            received_q <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            max_q      <= '0;
`ifdef ARGMAX_TOP2_EN
            sec_idx_q  <= '0;
            sec_val_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            received_q <= received_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
`ifdef ARGMAX_TOP2_EN
            sec_idx_q  <= sec_idx_d;
            sec_val_q  <= sec_val_d;
`endif
        end
    end

    assign received  = received_q;
    assign done      = done_q;
    assign class_idx = idx_q;
    assign max_value = max_q;
`ifdef ARGMAX_TOP2_EN
    assign second_idx = sec_idx_q;
    assign second_val = sec_val_q;
`endif

endmodule
